aes_sbox_column_feeder: RTL

Sequential wrapper that streams a 128-bit AES state, one 32-bit column per cycle, through the existing 4-byte SubBytes word datapath and reassembles the substituted state. It sits between the round-state register and the SubBytes word datapath. It drives that datapath's 32-bit input, captures its 32-bit output, and optionally folds ShiftRows into the reassembly. Upstream and downstream are valid/ready handshakes.

---
 rtl/aes_sbox_column_feeder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/aes_sbox_column_feeder.sv
// Streams a 128-bit AES state one column per cycle through an external SubBytes word datapath
// and reassembles the result. Define AES_FEEDER_SHIFTROWS_EN to fold ShiftRows into reassembly.
module aes_sbox_column_feeder #(
  parameter int unsigned SB_LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic [31:0]  sb_x,
  input  logic [31:0]  sb_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   iss_cnt_q, iss_cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] res_q, res_d;
  logic         out_valid_q, out_valid_d;
  logic         issue;
  logic         cap_vld;
  logic [1:0]   cap_idx;
  logic [1:0]   dst_col;

  assign issue = (state_q == StFeed);

  // Tag pipeline mirrors the external datapath latency so each sb_y lands in its own column.
  if (SB_LAT == 0) begin : g_comb
    assign cap_vld = issue;
    assign cap_idx = iss_cnt_q;
  end else begin : g_pipe
    logic [SB_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [1:0]        tag_idx_q [SB_LAT];
    logic [1:0]        tag_idx_d [SB_LAT];

    always_comb begin
      tag_vld_d[0] = issue;
      tag_idx_d[0] = iss_cnt_q;
      for (int i = 1; i < SB_LAT; i++) begin
        tag_vld_d[i] = tag_vld_q[i-1];
        tag_idx_d[i] = tag_idx_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_vld_q <= '0;
        for (int i = 0; i < SB_LAT; i++) tag_idx_q[i] <= '0;
      end else begin
        tag_vld_q <= tag_vld_d;
        for (int i = 0; i < SB_LAT; i++) tag_idx_q[i] <= tag_idx_d[i];
      end
    end

    assign cap_vld = tag_vld_q[SB_LAT-1];
    assign cap_idx = tag_idx_q[SB_LAT-1];
  end

  always_comb begin
    state_d     = state_q;
    iss_cnt_d   = iss_cnt_q;
    st_d        = st_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          st_d      = in_state;
          iss_cnt_d = '0;
          state_d   = StFeed;
        end
      end
      StFeed: begin
        iss_cnt_d = iss_cnt_q + 2'd1;
        if (iss_cnt_q == 2'd3) begin
          if (SB_LAT == 0) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (cap_vld && (cap_idx == 2'd3)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte row r of the captured word goes to column (idx - r) mod 4 when ShiftRows is folded in.
  always_comb begin
    res_d   = res_q;
    dst_col = '0;
    if (cap_vld) begin
      for (int r = 0; r < 4; r++) begin
`ifdef AES_FEEDER_SHIFTROWS_EN
        dst_col = cap_idx - 2'(r);
`else
        dst_col = cap_idx;
`endif
        res_d[8*(15 - 4*int'(dst_col) - r) +: 8] = sb_y[8*(3 - r) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      iss_cnt_q   <= '0;
      st_q        <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iss_cnt_q   <= iss_cnt_d;
      st_q        <= st_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    sb_x = '0;
    if (state_q == StFeed) sb_x = st_q[32*(3 - int'(iss_cnt_q)) +: 32];
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_state = res_q;

endmodule
